// File: rtl/icebreaker_7sd_ctrl_pkg.sv
// Shared constants for the 7-segment display register block: register map,
// CTRL bit positions, blank pattern and the active-low hex font.
package icebreaker_7sd_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLINK = 1;
  localparam int CTRL_RAW   = 2;
  localparam int CTRL_LZB   = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit0 = seg A .. bit6 = seg G
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/icebreaker_7sd_ctrl_if.sv
// Wishbone classic slave bus bundle for the display register block.
interface icebreaker_7sd_ctrl_if;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/icebreaker_7sd_ctrl_hex7seg.sv
// Nibble to active-low 7-segment pattern, purely combinational.
module hex7seg_decode
  import icebreaker_7sd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_FONT[nib];
endmodule

// File: rtl/icebreaker_7sd_ctrl.sv
// Wishbone register block feeding the 7-segment PMOD mux: holds DATA/CTRL,
// decodes two hex digits, blanks a leading zero and blinks the display.
module icebreaker_7sd_ctrl
  import icebreaker_7sd_pkg::*;
#(
  parameter int BLINK_W = 23
) (
  input  logic                 clk,
  input  logic                 rstz,
  icebreaker_7sd_ctrl_if.slave wb,
  output logic [6:0]           a,
  output logic [6:0]           b,
  output logic                 en
);

  logic [15:0]        data_q, data_nxt;
  logic [3:0]         ctrl_q, ctrl_nxt;
  logic [BLINK_W-1:0] cnt_q;
  logic               phase_q;
  logic               ack_q;
  logic [31:0]        dat_q, rdata;
  logic               acc, wr;
  reg_e               idx;
  logic [6:0]         seg_hi, seg_lo, a_nxt, b_nxt;
  logic               unused_ok;

  assign idx = reg_e'(wb.wb_adr_i[3:2]);
  // A new access is accepted only when ack is low, so a held strobe acks every other cycle
  assign acc = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr  = acc & wb.wb_we_i;

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

  assign unused_ok = ^{wb.wb_adr_i[1:0], wb.wb_dat_i[31:16], wb.wb_sel_i[3:2], data_q[15]};

  // Byte-lane merge of bus writes into DATA and CTRL
  always_comb begin
    data_nxt = data_q;
    ctrl_nxt = ctrl_q;
    if (wr && idx == REG_DATA) begin
      if (wb.wb_sel_i[0]) data_nxt[7:0]  = wb.wb_dat_i[7:0];
      if (wb.wb_sel_i[1]) data_nxt[15:8] = wb.wb_dat_i[15:8];
    end
    if (wr && idx == REG_CTRL && wb.wb_sel_i[0]) ctrl_nxt = wb.wb_dat_i[3:0];
  end

  // Read mux; unimplemented bits and the reserved slot read as zero
  always_comb begin
    rdata = '0;
    case (idx)
      REG_DATA:   rdata[15:0] = data_q;
      REG_CTRL:   rdata[3:0]  = ctrl_q;
      REG_STATUS: rdata[0]    = phase_q;
      default:    rdata       = '0;
    endcase
  end

  // Blink timer: counts only while blink is on now and stays on; a write
  // clearing blink snaps the phase back to "on" on the commit edge
  always_ff @(posedge clk) begin
    if (!rstz) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (!ctrl_q[CTRL_BLINK] || !ctrl_nxt[CTRL_BLINK]) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + BLINK_W'(1);
      if (&cnt_q) phase_q <= ~phase_q;
    end
  end

  hex7seg_decode u_dec_hi (.nib(data_q[7:4]), .seg(seg_hi));
  hex7seg_decode u_dec_lo (.nib(data_q[3:0]), .seg(seg_lo));

  // Pattern select: raw/hex, leading-zero blank on digit A, blink-off blank
  always_comb begin
    a_nxt = seg_hi;
    b_nxt = seg_lo;
    if (ctrl_q[CTRL_RAW]) begin
      a_nxt = data_q[6:0];
      b_nxt = data_q[14:8];
    end else if (ctrl_q[CTRL_LZB] && data_q[7:4] == 4'h0) begin
      a_nxt = SEG_BLANK;
    end
    if (!phase_q) begin
      a_nxt = SEG_BLANK;
      b_nxt = SEG_BLANK;
    end
  end

  // Register state, bus response and display outputs
  always_ff @(posedge clk) begin
    if (!rstz) begin
      data_q <= '0;
      ctrl_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      a      <= SEG_BLANK;
      b      <= SEG_BLANK;
      en     <= 1'b0;
    end else begin
      data_q <= data_nxt;
      ctrl_q <= ctrl_nxt;
      ack_q  <= acc;
      dat_q  <= acc ? rdata : '0;
      a      <= a_nxt;
      b      <= b_nxt;
      en     <= ctrl_q[CTRL_EN];
    end
  end

endmodule

// File: tb/tb_icebreaker_7sd_ctrl.sv
// Scoreboard bench for the 7-segment register block (short blink period).
module tb_icebreaker_7sd_ctrl;
  localparam int BW = 4;

  logic       clk  = 1'b0;
  logic       rstz = 1'b0;
  logic [6:0] a, b;
  logic       en;

  icebreaker_7sd_ctrl_if wb();

  icebreaker_7sd_ctrl #(.BLINK_W(BW)) dut (
    .clk (clk),
    .rstz(rstz),
    .wb  (wb),
    .a   (a),
    .b   (b),
    .en  (en)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
    logic       en;
  } disp_t;

  logic [31:0] rdq[$];
  disp_t       dq[$];

  // Blink reference: phase flips after every 2**BW counting cycles
  logic          mdl_run = 1'b0;
  logic [BW-1:0] mcnt;
  logic          mph, mblank;

  always @(posedge clk) begin
    if (!mdl_run) begin
      mcnt   <= '0;
      mph    <= 1'b1;
      mblank <= 1'b0;
    end else begin
      mcnt   <= mcnt + 1'b1;
      if (&mcnt) mph <= ~mph;
      mblank <= ~mph;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_sel_i = '0;
  endtask

  task automatic bus_drive(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
  endtask

  // One transaction; returns one step after the acking edge, bus idle
  task automatic xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input string tag);
    bit got = 0;
    logic [31:0] exp;
    @(negedge clk);
    bus_drive(we, adr, dat, sel);
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o) got = 1;
    end
    chk({tag, "_ack"}, {31'b0, wb.wb_ack_o}, 32'd1);
    if (!we) begin
      exp = rdq.pop_front();
      if (got) chk(tag, wb.wb_dat_o, exp);
    end
    bus_idle();
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    xfer(1'b1, adr, dat, sel, "wr");
  endtask

  task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string tag);
    rdq.push_back(exp);
    xfer(1'b0, adr, 32'h0, 4'hF, tag);
  endtask

  task automatic disp_push(input logic [6:0] ea, input logic [6:0] eb, input logic een);
    dq.push_back({ea, eb, een});
  endtask

  // Outputs settle one edge after the commit edge
  task automatic disp_chk(input string tag);
    disp_t d;
    @(posedge clk); #1;
    d = dq.pop_front();
    chk({tag, "_a"},  {25'b0, a},  {25'b0, d.a});
    chk({tag, "_b"},  {25'b0, b},  {25'b0, d.b});
    chk({tag, "_en"}, {31'b0, en}, {31'b0, d.en});
  endtask

  initial begin
    bus_idle();
    rstz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a",   {25'b0, a}, 32'h7F);
    chk("rst_b",   {25'b0, b}, 32'h7F);
    chk("rst_en",  {31'b0, en}, 32'd0);
    chk("rst_ack", {31'b0, wb.wb_ack_o}, 32'd0);
    chk("rst_dat", wb.wb_dat_o, 32'd0);
    @(negedge clk);
    rstz = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_en",  {31'b0, en}, 32'd0);
    chk("idle_ack", {31'b0, wb.wb_ack_o}, 32'd0);
    rd(4'h8, 32'h1, "status_rst");
    rd(4'h4, 32'h0, "ctrl_rst");

    // Hex display with enable
    wr(4'h4, 32'h1, 4'hF);
    wr(4'h0, 32'h3A, 4'hF);
    disp_push(7'h30, 7'h08, 1'b1);
    disp_chk("hex3a");
    rd(4'h0, 32'h3A, "rd_data");
    @(posedge clk); #1;
    chk("ack_single", {31'b0, wb.wb_ack_o}, 32'd0);
    chk("dat_o_zero", wb.wb_dat_o, 32'd0);

    // Leading-zero blanking
    wr(4'h4, 32'h9, 4'hF);
    wr(4'h0, 32'h05, 4'hF);
    disp_push(7'h7F, 7'h12, 1'b1);
    disp_chk("lzb05");
    wr(4'h0, 32'h00, 4'hF);
    disp_push(7'h7F, 7'h40, 1'b1);
    disp_chk("lzb00");
    wr(4'h4, 32'h1, 4'hF);
    disp_push(7'h40, 7'h40, 1'b1);
    disp_chk("nolzb00");

    // Raw mode, lzb has no effect
    wr(4'h4, 32'h5, 4'hF);
    wr(4'h0, 32'h2479, 4'hF);
    disp_push(7'h79, 7'h24, 1'b1);
    disp_chk("raw");
    wr(4'h4, 32'hD, 4'hF);
    disp_push(7'h79, 7'h24, 1'b1);
    disp_chk("raw_lzb");

    // Blink: hex of 0x79 -> a=78, b=10
    wr(4'h4, 32'h3, 4'hF);
    mdl_run = 1'b1;
    rd(4'h8, {31'b0, mph}, "status_on");
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("blink_a", {25'b0, a}, mblank ? 32'h7F : 32'h78);
      chk("blink_en", {31'b0, en}, 32'd1);
    end
    for (int i = 0; i < 40 && !mblank; i++) begin
      @(posedge clk); #1;
    end
    chk("off_a", {25'b0, a}, 32'h7F);
    chk("off_b", {25'b0, b}, 32'h7F);
    rd(4'h8, {31'b0, mph}, "status_off");
    wr(4'h4, 32'h1, 4'hF);
    mdl_run = 1'b0;
    chk("clr_still_off", {25'b0, a}, 32'h7F);
    disp_push(7'h78, 7'h10, 1'b1);
    disp_chk("blink_clr");
    rd(4'h8, 32'h1, "status_clr");

    // Byte-lane write
    wr(4'h0, 32'h0012, 4'hF);
    wr(4'h0, 32'hFFFF, 4'b0010);
    rd(4'h0, 32'hFF12, "sel_lane");
    disp_push(7'h79, 7'h24, 1'b1);
    disp_chk("lane_disp");

    // Held strobe: ack on cycles 1, 3, 5
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus_drive(1'b0, 4'h0, 32'h0, 4'hF);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("held_ack%0d", k), {31'b0, wb.wb_ack_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    bus_idle();

    // Reset while ack is high drops it
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus_drive(1'b1, 4'h0, 32'h00AB, 4'hF);
    @(posedge clk); #1;
    chk("pre_rst_ack", {31'b0, wb.wb_ack_o}, 32'd1);
    rstz = 1'b0;
    @(posedge clk); #1;
    chk("rst_drop_ack", {31'b0, wb.wb_ack_o}, 32'd0);
    bus_idle();
    // Write attempted under reset gets no ack and no commit
    @(negedge clk);
    bus_drive(1'b1, 4'h0, 32'h00CD, 4'hF);
    @(posedge clk); #1;
    chk("rst_wr_ack", {31'b0, wb.wb_ack_o}, 32'd0);
    chk("rst_wr_a", {25'b0, a}, 32'h7F);
    bus_idle();
    @(negedge clk);
    rstz = 1'b1;
    rd(4'h0, 32'h0, "rst_data");
    rd(4'h4, 32'h0, "rst_ctrl");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
